mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port (CPU / host) round-robin arbiter in front of a single fixed-latency memory port.
// Each access runs ISSUE -> WAIT (MEM_LAT cycles) -> ACK and is always followed by at least one IDLE cycle.
module mem_port_arbiter #(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        gnt,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  localparam logic [1:0] CNT_LAST = 2'(MEM_LAT - 1);

  state_t              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                last_host_q, last_host_d;
  logic                own_host_q, own_host_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [1:0]          gnt_q, gnt_d;
  logic                busy_q, busy_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                host_ack_q, host_ack_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   host_rdata_q, host_rdata_d;
  logic                win_host;

  // On a tie the port that was not served last wins.
  assign win_host = host_req & (~cpu_req | ~last_host_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_host_d  = last_host_q;
    own_host_d   = own_host_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    gnt_d        = gnt_q;
    busy_d       = busy_q;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    cpu_ack_d    = 1'b0;
    host_ack_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req | host_req) begin
          state_d     = ISSUE;
          own_host_d  = win_host;
          last_host_d = win_host;
          we_d        = win_host ? host_we    : cpu_we;
          addr_d      = win_host ? host_addr  : cpu_addr;
          wdata_d     = win_host ? host_wdata : cpu_wdata;
          mem_en_d    = 1'b1;
          mem_we_d    = win_host ? host_we    : cpu_we;
          gnt_d       = win_host ? 2'b10 : 2'b01;
          busy_d      = 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = 2'd0;
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          // Final WAIT edge: the memory word is valid now, capture it for the owner.
          state_d = ACK;
          cnt_d   = 2'd0;
          if (own_host_q) begin
            host_ack_d   = 1'b1;
            host_rdata_d = mem_rdata;
          end else begin
            cpu_ack_d   = 1'b1;
            cpu_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = 2'(cnt_q + 2'd1);
        end
      end
      ACK: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      last_host_q  <= 1'b1;
      own_host_q   <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      gnt_q        <= 2'b00;
      busy_q       <= 1'b0;
      cpu_ack_q    <= 1'b0;
      host_ack_q   <= 1'b0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_host_q  <= last_host_d;
      own_host_q   <= own_host_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      gnt_q        <= gnt_d;
      busy_q       <= busy_d;
      cpu_ack_q    <= cpu_ack_d;
      host_ack_q   <= host_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign gnt        = gnt_q;
  assign busy       = busy_q;
  assign cpu_ack    = cpu_ack_q;
  assign host_ack   = host_ack_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign host_rdata = host_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter: a transaction-level model predicts memory strobes and acks,
// a negedge monitor compares them, and a behavioural memory answers MEM_LAT cycles after each strobe.
module tb_mem_port_arbiter;
  localparam int LAT = 3;
  localparam int AW  = 8;
  localparam int DW  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          host_req = 1'b0, host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          host_ack;
  logic [DW-1:0] host_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [1:0]    gnt;
  logic          busy;

  mem_port_arbiter #(.MEM_LAT(LAT), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .gnt(gnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; bit we; logic [AW-1:0] addr; logic [DW-1:0] wdata;} mem_op_t;
  typedef struct {int cyc; bit host; bit we; logic [DW-1:0] data;} ack_t;

  mem_op_t       mq[$];
  ack_t          aq[$];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  logic [DW-1:0] model_mem[256];
  logic [DW-1:0] bench_mem[256];
  logic [DW-1:0] pending[int];
  logic [DW-1:0] drv[int];
  int            next_free = 0, own_start = 0, own_end = -1;
  bit            own_host = 1'b0, last_host = 1'b1, started = 1'b0;
  logic [DW-1:0] last_cpu_rd = '0, last_host_rd = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  // Reference model: a transaction accepted at cycle c strobes memory at c+1 and acks at c+LAT+2.
  always @(posedge clk) begin
    if (rst) begin
      started = 1'b1;
      mq.delete();
      aq.delete();
      next_free = cyc + 1;
      own_end = -1;
      last_host = 1'b1;
      last_cpu_rd = '0;
      last_host_rd = '0;
    end else if (started && cyc >= next_free && (cpu_req || host_req)) begin
      mem_op_t m;
      ack_t a;
      bit h;
      h = host_req && (!cpu_req || !last_host);
      last_host = h;
      m.cyc = cyc + 1;
      m.we = h ? host_we : cpu_we;
      m.addr = h ? host_addr : cpu_addr;
      m.wdata = h ? host_wdata : cpu_wdata;
      a.cyc = cyc + LAT + 2;
      a.host = h;
      a.we = m.we;
      a.data = model_mem[m.addr];
      if (m.we) model_mem[m.addr] = m.wdata;
      mq.push_back(m);
      aq.push_back(a);
      own_host = h;
      own_start = cyc + 1;
      own_end = cyc + LAT + 2;
      next_free = cyc + LAT + 3;
    end
    cyc++;
  end

  // Monitor plus behavioural memory.
  always @(negedge clk) begin
    logic [DW-1:0] d;
    if (started) begin
      bit eg;
      eg = (cyc >= own_start) && (cyc <= own_end);
      check("gnt", gnt, eg ? (own_host ? 2 : 1) : 0);
      check("busy", busy, eg);
      if (mem_en) begin
        if (mq.size() == 0) check("unexp_mem", mem_en, 0);
        else begin
          mem_op_t m;
          m = mq.pop_front();
          check("mem_cyc", cyc, m.cyc);
          check("mem_we", mem_we, m.we);
          check("mem_addr", mem_addr, m.addr);
          if (m.we) check("mem_wdata", mem_wdata, m.wdata);
        end
      end else begin
        check("mem_we_idle", mem_we, 0);
        if (mq.size() != 0 && mq[0].cyc <= cyc) begin
          check("missing_mem", mem_en, 1);
          void'(mq.pop_front());
        end
      end
      check("ack_onehot", cpu_ack & host_ack, 0);
      if (cpu_ack || host_ack) begin
        if (aq.size() == 0) check("unexp_ack", {cpu_ack, host_ack}, 0);
        else begin
          ack_t a;
          logic [DW-1:0] exp;
          a = aq.pop_front();
          exp = a.we ? drv[cyc-1] : a.data;
          check("ack_cyc", cyc, a.cyc);
          check("ack_who", host_ack, a.host);
          check("ack_rdata", host_ack ? host_rdata : cpu_rdata, exp);
          if (a.host) last_host_rd = exp;
          else last_cpu_rd = exp;
        end
      end else if (aq.size() != 0 && aq[0].cyc <= cyc) begin
        check("missing_ack", {host_ack, cpu_ack}, aq[0].host ? 2 : 1);
        void'(aq.pop_front());
      end
      if (!cpu_ack) check("cpu_hold", cpu_rdata, last_cpu_rd);
      if (!host_ack) check("host_hold", host_rdata, last_host_rd);
    end
    d = pending.exists(cyc) ? pending[cyc] : DW'($urandom);
    pending.delete(cyc);
    mem_rdata = d;
    drv[cyc] = d;
    if (mem_en === 1'b1) begin
      if (mem_we) bench_mem[mem_addr] = mem_wdata;
      else pending[cyc + LAT] = bench_mem[mem_addr];
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      bench_mem[i] = DW'($urandom);
      model_mem[i] = bench_mem[i];
    end
    bench_mem[8'h10] = 16'h1234;
    model_mem[8'h10] = 16'h1234;
    step(3);
    rst = 1'b0;
    step(2);
    // CPU read of 0x10, request dropped after one cycle
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    step(1);
    cpu_req = 1'b0;
    step(LAT + 5);
    $display("txn cpu read 0x10 done at cyc=%0d", cyc);
    // Host write 0x20 <= 0xBEEF, then CPU reads it back
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h20; host_wdata = 16'hBEEF;
    step(1);
    host_req = 1'b0;
    step(LAT + 5);
    $display("txn host write 0x20 done at cyc=%0d", cyc);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20;
    step(1);
    cpu_req = 1'b0;
    step(LAT + 5);
    $display("txn cpu read 0x20 done at cyc=%0d", cyc);
    // Both held: grants must alternate; CPU address churns mid-transaction
    cpu_req = 1'b1; host_req = 1'b1; host_we = 1'b0;
    for (int i = 0; i < 8 * (LAT + 3); i++) begin
      cpu_addr = AW'($urandom_range(0, 15));
      host_addr = AW'($urandom_range(0, 15));
      step(1);
    end
    cpu_req = 1'b0; host_req = 1'b0;
    step(LAT + 5);
    $display("txn contention burst done at cyc=%0d", cyc);
    // Reset during WAIT aborts the read
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05;
    step(1);
    cpu_req = 1'b0;
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(LAT + 5);
    $display("txn reset-in-wait done at cyc=%0d", cyc);
    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cpu_req = 1'($urandom_range(0, 1));
      cpu_we = 1'($urandom_range(0, 1));
      cpu_addr = AW'($urandom_range(0, 15));
      cpu_wdata = DW'($urandom);
      host_req = 1'($urandom_range(0, 1));
      host_we = 1'($urandom_range(0, 1));
      host_addr = AW'($urandom_range(0, 15));
      host_wdata = DW'($urandom);
      step(1);
    end
    cpu_req = 1'b0; host_req = 1'b0;
    step(LAT + 6);
    $display("txn random phase done at cyc=%0d", cyc);
    check("drain_mem", mq.size(), 0);
    check("drain_ack", aq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
